// File: rtl/mac_scheduler_if.sv
// Bundle of feature-input handshake, weight-ROM, external-MAC and result signals for mac_scheduler.
// master = scheduler side, slave = surrounding datapath / testbench.
interface mac_scheduler_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int ACC_W = 20
);
  localparam int ADDR_W = $clog2(N_IN * N_OUT);

  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;

  logic [ADDR_W-1:0] w_addr;
  logic              w_rd_en;
  logic [7:0]        w_data;

  logic              mac_clr;
  logic              mac_en;
  logic [7:0]        mac_x;
  logic [7:0]        mac_w;
  logic [ACC_W-1:0]  mac_acc;

  logic              busy;
  logic [3:0]        result_data;
  logic              result_valid;

  modport master (
    input  start, in_data, in_valid, w_data, mac_acc,
    output in_ready, w_addr, w_rd_en, mac_clr, mac_en, mac_x, mac_w,
           busy, result_data, result_valid
  );

  modport slave (
    output start, in_data, in_valid, w_data, mac_acc,
    input  in_ready, w_addr, w_rd_en, mac_clr, mac_en, mac_x, mac_w,
           busy, result_data, result_valid
  );
endinterface

// File: rtl/mac_scheduler.sv
// Sequences one dense-layer inference over an external MAC and weight ROM, then reports the argmax neuron.
// Optional macro MAC_SCHED_RELU_EN clamps negative accumulator results to zero before comparison.
module mac_scheduler #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  mac_scheduler_if.master  bus
);
  localparam int ADDR_W = $clog2(N_IN * N_OUT);
  localparam int K_W    = $clog2(N_IN);

  localparam logic [K_W-1:0] LAST_K = K_W'(N_IN - 1);
  localparam logic [3:0]     LAST_J = 4'(N_OUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_CMP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]              r_state;
  logic [K_W-1:0]          r_k;
  logic [3:0]              r_j;
  logic [7:0]              r_buf [N_IN];
  logic signed [ACC_W-1:0] r_best;
  logic [3:0]              r_bestIdx;
  logic [3:0]              r_resultData;

  logic                    w_inIssue;
  logic                    w_inLast;
  logic                    w_macEn;
  logic [ADDR_W-1:0]       w_addrCalc;
  logic [7:0]              w_macX;
  logic signed [ACC_W-1:0] w_score;
  logic                    w_better;
  logic [3:0]              w_newBestIdx;

  assign w_inIssue  = (r_state == S_ISSUE);
  assign w_inLast   = (r_state == S_LAST);
  assign w_macEn    = (w_inIssue && (r_k != '0)) || w_inLast;
  assign w_addrCalc = ADDR_W'(int'(r_j) * N_IN + int'(r_k));

  // The ROM answers one cycle late, so the MAC operand pair always trails the issued address by one feature.
  assign w_macX = w_inLast ? r_buf[N_IN-1] : r_buf[r_k - 1'b1];

`ifdef MAC_SCHED_RELU_EN
  assign w_score = bus.mac_acc[ACC_W-1] ? '0 : $signed(bus.mac_acc);
`else
  assign w_score = $signed(bus.mac_acc);
`endif

  // Strict compare keeps the lower index on ties; neuron 0 always seeds the running best.
  assign w_better     = (r_j == 4'd0) || (w_score > r_best);
  assign w_newBestIdx = w_better ? r_j : r_bestIdx;

  assign bus.in_ready     = (r_state == S_LOAD);
  assign bus.w_rd_en      = w_inIssue;
  assign bus.w_addr       = w_inIssue ? w_addrCalc : '0;
  assign bus.mac_clr      = w_inIssue && (r_k == '0);
  assign bus.mac_en       = w_macEn;
  assign bus.mac_x        = w_macEn ? w_macX : 8'd0;
  assign bus.mac_w        = w_macEn ? bus.w_data : 8'd0;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.result_data  = r_resultData;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_j          <= '0;
      r_best       <= '0;
      r_bestIdx    <= '0;
      r_resultData <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k     <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            r_buf[r_k] <= bus.in_data;
            if (r_k == LAST_K) begin
              r_k     <= '0;
              r_j     <= '0;
              r_state <= S_ISSUE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (r_k == LAST_K) begin
            r_state <= S_LAST;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_LAST: r_state <= S_WAIT;
        S_WAIT: r_state <= S_CMP;
        S_CMP: begin
          if (w_better) begin
            r_best    <= w_score;
            r_bestIdx <= r_j;
          end
          // Capture the final winner here so result_data is already valid during the DONE pulse.
          if (r_j == LAST_J) begin
            r_resultData <= w_newBestIdx;
            r_state      <= S_DONE;
          end else begin
            r_j     <= r_j + 4'd1;
            r_k     <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_scheduler.sv
// Self-checking bench for mac_scheduler: ROM and MAC models around the DUT, reference argmax model, protocol monitor.
// Honours MAC_SCHED_RELU_EN in the reference model the same way the design does.
module tb_mac_scheduler;
  localparam int N_IN    = 16;
  localparam int N_OUT   = 10;
  localparam int ACC_W   = 20;
  localparam int N_W     = N_IN * N_OUT;
  localparam int LATENCY = N_OUT * (N_IN + 3);
  localparam int ADDR_W  = $clog2(N_W);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  mac_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) bus ();

  mac_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment models: registered weight ROM and an accumulating MAC, both one cycle behind their strobes.
  logic signed [7:0]       rom [N_W];
  logic [7:0]              romData = 8'd0;
  logic signed [ACC_W-1:0] macAcc  = '0;
  int                      xs [N_IN];

  assign bus.w_data  = romData;
  assign bus.mac_acc = macAcc;

  always @(posedge clk) begin
    if (bus.w_rd_en) romData <= rom[bus.w_addr];
    if (bus.mac_clr) macAcc <= '0;
    else if (bus.mac_en)
      macAcc <= macAcc + ACC_W'(int'(bus.mac_x) * int'($signed(bus.mac_w)));
  end

  // Protocol monitor: contiguous ROM addresses, clear only on a neuron's first address, idle fields held at zero.
  int macEnCnt  = 0;
  int macClrCnt = 0;
  int rdCnt     = 0;
  int protoErr  = 0;
  int validCnt  = 0;
  int addrNext  = 0;

  always @(negedge clk) begin
    if (bus.w_rd_en) begin
      rdCnt    <= rdCnt + 1;
      addrNext <= (addrNext + 1) % N_W;
      if (bus.w_addr !== ADDR_W'(addrNext)) protoErr <= protoErr + 1;
    end else if (bus.w_addr !== '0) begin
      protoErr <= protoErr + 1;
    end
    if (bus.mac_clr) begin
      macClrCnt <= macClrCnt + 1;
      if (!bus.w_rd_en || (int'(bus.w_addr) % N_IN) != 0 || bus.mac_en) protoErr <= protoErr + 1;
    end
    if (bus.mac_en) macEnCnt <= macEnCnt + 1;
    else if (bus.mac_x !== 8'd0 || bus.mac_w !== 8'd0) protoErr <= protoErr + 1;
    if (bus.result_valid === 1'b1) validCnt <= validCnt + 1;
    if (reset) addrNext <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each neuron's score is a plain dot product; the winner is the first index holding the maximum.
  function automatic int refWinner();
    int best = 0;
    int bestIdx = 0;
    for (int j = 0; j < N_OUT; j++) begin
      int s = 0;
      for (int k = 0; k < N_IN; k++) s += xs[k] * int'(rom[j * N_IN + k]);
`ifdef MAC_SCHED_RELU_EN
      if (s < 0) s = 0;
`endif
      if (j == 0 || s > best) begin
        best    = s;
        bestIdx = j;
      end
    end
    return bestIdx;
  endfunction

  task automatic startAndLoad(input int gapMode);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    checkOutput("load_in_ready", bus.in_ready, 1);
    checkOutput("load_busy", bus.busy, 1);
    for (int i = 0; i < N_IN; i++) begin
      int gap;
      gap = (gapMode == 1) ? 1 : ((gapMode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(xs[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("issue_entry_rd_en", bus.w_rd_en, 1);
    checkOutput("issue_entry_addr", bus.w_addr, 0);
    checkOutput("issue_entry_in_ready", bus.in_ready, 0);
  endtask

  task automatic applyStimulus(input string name, input int gapMode, input bit pokeStart);
    int expIdx;
    int n;
    bit seen;
    int en0, clr0, rd0, val0;
    expIdx = refWinner();
    en0 = macEnCnt; clr0 = macClrCnt; rd0 = rdCnt; val0 = validCnt;
    $display("[TB] inference %s expecting class %0d", name, expIdx);
    startAndLoad(gapMode);
    n = 0;
    seen = 1'b0;
    while (n < LATENCY + 50 && !seen) begin
      bus.start    = pokeStart && (n == 40);
      bus.in_valid = pokeStart && (n % 3 == 0);
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput({name, "_result_seen"}, 32'(seen), 1);
    checkOutput({name, "_latency"}, n, LATENCY);
    checkOutput({name, "_result_data"}, bus.result_data, expIdx);
    @(posedge clk); #1;
    checkOutput({name, "_valid_one_cycle"}, bus.result_valid, 0);
    checkOutput({name, "_idle_busy"}, bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_result_hold"}, bus.result_data, expIdx);
    checkOutput({name, "_mac_en_count"}, macEnCnt - en0, N_IN * N_OUT);
    checkOutput({name, "_mac_clr_count"}, macClrCnt - clr0, N_OUT);
    checkOutput({name, "_rom_reads"}, rdCnt - rd0, N_W);
    checkOutput({name, "_valid_pulses"}, validCnt - val0, 1);
  endtask

  task automatic setPatternSeven();
    for (int k = 0; k < N_IN; k++) xs[k] = 1;
    for (int a = 0; a < N_W; a++) rom[a] = (a / N_IN == 7) ? 8'sd2 : 8'sd1;
  endtask

  initial begin
    int tmo;
    int val0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    for (int a = 0; a < N_W; a++) rom[a] = 8'sd0;
    for (int k = 0; k < N_IN; k++) xs[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_rd_en", bus.w_rd_en, 0);
    checkOutput("reset_mac_en", bus.mac_en, 0);
    checkOutput("reset_mac_clr", bus.mac_clr, 0);
    checkOutput("reset_valid", bus.result_valid, 0);
    checkOutput("reset_result", bus.result_data, 0);
    reset = 1'b0;

    setPatternSeven();
    applyStimulus("neuron7", 0, 1'b1);

    for (int k = 0; k < N_IN; k++) xs[k] = 1;
    for (int a = 0; a < N_W; a++) begin
      int j = a / N_IN;
      int k = a % N_IN;
      if (j == 2 || j == 5) rom[a] = (k < 8) ? 8'sd5 : 8'sd0;
      else rom[a] = 8'sd2;
    end
    applyStimulus("tie", 0, 1'b0);

    for (int a = 0; a < N_W; a++) begin
      int j = a / N_IN;
      int k = a % N_IN;
      if (j == 4) rom[a] = (k < 3) ? -8'sd1 : 8'sd0;
      else rom[a] = -8'sd1;
    end
    applyStimulus("negative", 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 255));
      for (int a = 0; a < N_W; a++) rom[a] = 8'($urandom);
      applyStimulus($sformatf("random%0d", r), (r == 0) ? 1 : 2, r[0]);
    end

    setPatternSeven();
    applyStimulus("before_abort", 1, 1'b0);

    val0 = validCnt;
    startAndLoad(0);
    tmo = 0;
    while (!(bus.w_rd_en === 1'b1 && bus.w_addr === ADDR_W'(3 * N_IN + 5)) && tmo < LATENCY) begin
      @(posedge clk); #1;
      tmo++;
    end
    checkOutput("abort_reached_j3", 32'(tmo < LATENCY), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_rd_en", bus.w_rd_en, 0);
    checkOutput("abort_mac_en", bus.mac_en, 0);
    checkOutput("abort_mac_clr", bus.mac_clr, 0);
    checkOutput("abort_in_ready", bus.in_ready, 0);
    checkOutput("abort_result", bus.result_data, 0);
    repeat (LATENCY + 20) @(posedge clk);
    #1;
    checkOutput("abort_no_valid", validCnt - val0, 0);
    checkOutput("abort_still_idle", bus.busy, 0);

    for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 255));
    for (int a = 0; a < N_W; a++) rom[a] = 8'($urandom);
    applyStimulus("recovery", 2, 1'b1);

    checkOutput("protocol_errors", protoErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
